// File: rtl/pc_gen_pkg.sv
// Shared fetch-stage definitions: flow-control encodings, reset vector default and next-PC source select.
// Used by pc_gen and pc_ras; the RVC_EN macro (16-bit instruction support) is consumed in pc_gen.
package pc_gen_pkg;

   localparam int FLOW_WIDTH = 2;

   localparam logic [FLOW_WIDTH-1:0] FLOW_WORK    = 2'd0;
   localparam logic [FLOW_WIDTH-1:0] FLOW_STOP    = 2'd1;
   localparam logic [FLOW_WIDTH-1:0] FLOW_REFRESH = 2'd2;

   localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

   typedef enum logic [2:0] {
      SEL_RESET,
      SEL_TRAP,
      SEL_HOLD,
      SEL_REDIR,
      SEL_RAS,
      SEL_SEQ
   } pc_sel_e;

   // Any code other than WORK/STOP restarts the fetch stream.
   function automatic logic flow_is_refresh(input logic [FLOW_WIDTH-1:0] flow);
      return (flow != FLOW_WORK) && (flow != FLOW_STOP);
   endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with a top pointer and saturating count.
// When full, a push overwrites the oldest entry; push+pop together replaces the top.
module pc_ras
   import pc_gen_pkg::*;
#(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] top_o,
   output logic         empty_o,
   output logic         full_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] top_q, top_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          empty_q, empty_d;
   logic          full_q, full_d;
   logic          non_empty;

   assign non_empty = (cnt_q != '0);

   always_comb begin
      mem_d = mem_q;
      top_d = top_q;
      cnt_d = cnt_q;
      if (clr_i) begin
         top_d = '0;
         cnt_d = '0;
      end else if (en_i) begin
         if (push_i && pop_i && non_empty) begin
            mem_d[top_q] = din_i;
         end else if (push_i) begin
            top_d        = top_q + PW'(1);
            mem_d[top_d] = din_i;
            if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
         end else if (pop_i && non_empty) begin
            top_d = top_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
         end
      end
      empty_d = (cnt_d == '0);
      full_d  = (cnt_d == CW'(DEPTH));
   end

   // Storage needs no reset: the count alone decides which entries are live.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (!rst_n) begin
         top_q   <= '0;
         cnt_q   <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         top_q   <= top_d;
         cnt_q   <= cnt_d;
         empty_q <= empty_d;
         full_q  <= full_d;
      end
   end

   assign top_o   = mem_q[top_q];
   assign empty_o = empty_q;
   assign full_o  = full_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: priority next-PC mux, PC register and RAS prediction.
// Define RVC_EN to enable 2-byte increments for 16-bit instructions and halfword alignment.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int                   CPU_WIDTH = 32,
   parameter logic [CPU_WIDTH-1:0] RESET_VEC = CPU_WIDTH'(RESET_VEC_DEFAULT),
   parameter int                   RAS_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  jtag_reset_flag_i,
   input  logic [FLOW_WIDTH-1:0] flow_pc_i,
   input  logic                  trap_valid_i,
   input  logic [CPU_WIDTH-1:0]  trap_pc_i,
   input  logic                  redir_valid_i,
   input  logic [CPU_WIDTH-1:0]  redir_pc_i,
   input  logic                  ras_push_i,
   input  logic [CPU_WIDTH-1:0]  ret_addr_i,
   input  logic                  ras_pop_i,
   input  logic                  inst_len16_i,
   output logic [CPU_WIDTH-1:0]  curr_pc_o,
   output logic                  pc_valid_o,
   output logic                  ras_empty_o,
   output logic                  ras_full_o,
   output logic                  misalign_o
);

   logic [CPU_WIDTH-1:0] pc_q, pc_d;
   logic                 valid_q, valid_d;
   logic [CPU_WIDTH-1:0] pc_inc;
   logic [CPU_WIDTH-1:0] ras_top;
   logic                 ras_clr;
   logic                 ras_en;
   pc_sel_e              pc_sel;

`ifdef RVC_EN
   assign pc_inc     = inst_len16_i ? CPU_WIDTH'(2) : CPU_WIDTH'(4);
   assign misalign_o = pc_q[0];
`else
   logic unused_len16;
   assign unused_len16 = inst_len16_i;
   assign pc_inc       = CPU_WIDTH'(4);
   assign misalign_o   = |pc_q[1:0];
`endif

   assign ras_clr = jtag_reset_flag_i || flow_is_refresh(flow_pc_i);
   assign ras_en  = (flow_pc_i == FLOW_WORK) && !trap_valid_i;

   always_comb begin
      pc_sel  = SEL_SEQ;
      pc_d    = pc_q + pc_inc;
      valid_d = 1'b1;
      if (ras_clr)                          pc_sel = SEL_RESET;
      else if (trap_valid_i)                pc_sel = SEL_TRAP;
      else if (flow_pc_i == FLOW_STOP)      pc_sel = SEL_HOLD;
      else if (redir_valid_i)               pc_sel = SEL_REDIR;
      else if (ras_pop_i && !ras_empty_o)   pc_sel = SEL_RAS;
      case (pc_sel)
         SEL_RESET: begin pc_d = RESET_VEC; valid_d = 1'b0; end
         SEL_TRAP:  pc_d = trap_pc_i;
         SEL_HOLD:  begin pc_d = pc_q; valid_d = valid_q; end
         SEL_REDIR: pc_d = redir_pc_i;
         SEL_RAS:   pc_d = ras_top;
         default:   pc_d = pc_q + pc_inc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q    <= RESET_VEC;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   pc_ras #(
      .W     (CPU_WIDTH),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (ras_clr),
      .en_i    (ras_en),
      .push_i  (ras_push_i),
      .pop_i   (ras_pop_i),
      .din_i   (ret_addr_i),
      .top_o   (ras_top),
      .empty_o (ras_empty_o),
      .full_o  (ras_full_o)
   );

   assign curr_pc_o  = pc_q;
   assign pc_valid_o = valid_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: reference model of the PC and a queue-based return stack feeding an expected queue.
module tb_pc_gen;
   import pc_gen_pkg::*;

   localparam int DEPTH = 4;
   localparam logic [31:0] RV = 32'h0;

   logic        clk;
   logic        rst_n;
   logic        jtag;
   logic [1:0]  flow;
   logic        trap;
   logic [31:0] tpc;
   logic        redir;
   logic [31:0] rpc;
   logic        push;
   logic [31:0] raddr;
   logic        pop;
   logic        len16;
   logic [31:0] curr_pc_o;
   logic        pc_valid_o, ras_empty_o, ras_full_o, misalign_o;

   pc_gen #(.CPU_WIDTH(32), .RESET_VEC(RV), .RAS_DEPTH(DEPTH)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .jtag_reset_flag_i (jtag),
      .flow_pc_i         (flow),
      .trap_valid_i      (trap),
      .trap_pc_i         (tpc),
      .redir_valid_i     (redir),
      .redir_pc_i        (rpc),
      .ras_push_i        (push),
      .ret_addr_i        (raddr),
      .ras_pop_i         (pop),
      .inst_len16_i      (len16),
      .curr_pc_o         (curr_pc_o),
      .pc_valid_o        (pc_valid_o),
      .ras_empty_o       (ras_empty_o),
      .ras_full_o        (ras_full_o),
      .misalign_o        (misalign_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run;
   int tests_failed;

   logic [35:0] exp_q[$];
   logic [31:0] m_pc;
   logic        m_valid;
   logic [31:0] m_stack[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic model_mis(input logic [31:0] p);
`ifdef RVC_EN
      return p[0];
`else
      return |p[1:0];
`endif
   endfunction

   function automatic logic [31:0] model_inc(input logic l16);
`ifdef RVC_EN
      return l16 ? 32'd2 : 32'd4;
`else
      return 32'd4;
`endif
   endfunction

   task automatic idle();
      jtag = 0; flow = FLOW_WORK; trap = 0; tpc = '0; redir = 0; rpc = '0;
      push = 0; raddr = '0; pop = 0; len16 = 0;
   endtask

   task automatic model_step();
      logic        hit;
      logic [31:0] pred;
      hit  = pop && (m_stack.size() > 0);
      pred = hit ? m_stack[$] : 32'h0;
      if (!rst_n || jtag || (flow != FLOW_WORK && flow != FLOW_STOP)) begin
         m_pc = RV; m_valid = 0; m_stack.delete();
      end else if (trap) begin
         m_pc = tpc; m_valid = 1;
      end else if (flow == FLOW_WORK) begin
         if (push && hit) m_stack[m_stack.size()-1] = raddr;
         else if (push) begin
            m_stack.push_back(raddr);
            if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
         end else if (hit) void'(m_stack.pop_back());
         if (redir)    m_pc = rpc;
         else if (hit) m_pc = pred;
         else          m_pc = m_pc + model_inc(len16);
         m_valid = 1;
      end
   endtask

   // Drive is already applied; model the edge, then sample 1 time unit after it.
   task automatic tick();
      logic [35:0] e;
      model_step();
      exp_q.push_back({m_pc, m_valid, m_stack.size() == 0, m_stack.size() == DEPTH, model_mis(m_pc)});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("queue_underflow", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check("pc",       curr_pc_o,        e[35:4]);
         check("valid",    32'(pc_valid_o),  32'(e[3]));
         check("empty",    32'(ras_empty_o), 32'(e[2]));
         check("full",     32'(ras_full_o),  32'(e[1]));
         check("misalign", 32'(misalign_o),  32'(e[0]));
      end
      idle();
   endtask

   initial begin
      tests_run = 0; tests_failed = 0;
      m_pc = 32'hdead_beef; m_valid = 1'bx;
      idle();
      rst_n = 0;
      #2;
      tick();
      check("rst_pc", curr_pc_o, 32'h0);
      check("rst_valid", 32'(pc_valid_o), 32'd0);
      check("rst_empty", 32'(ras_empty_o), 32'd1);
      rst_n = 1;

      tick(); tick(); tick();
      check("seq_c", curr_pc_o, 32'hC);
      tick();

      flow = FLOW_STOP; tick();
      check("stop_hold", curr_pc_o, 32'h10);
      flow = FLOW_STOP; trap = 1; tpc = 32'h80; tick();
      check("stop_trap", curr_pc_o, 32'h80);

      for (int i = 1; i <= 5; i++) begin
         push = 1; raddr = 32'(i) * 32'h100; tick();
      end
      check("push_full", 32'(ras_full_o), 32'd1);
      for (int k = 0; k < 4; k++) begin
         pop = 1; tick();
         check("pop_order", curr_pc_o, 32'h500 - 32'(k) * 32'h100);
      end
      pop = 1; tick();
      check("pop_empty_seq", curr_pc_o, 32'h204);
      check("pop_empty_flag", 32'(ras_empty_o), 32'd1);

      push = 1; raddr = 32'h300; tick();
      redir = 1; rpc = 32'h200; pop = 1; tick();
      check("redir_pop_pc", curr_pc_o, 32'h200);
      check("redir_pop_consumed", 32'(ras_empty_o), 32'd1);

      push = 1; raddr = 32'h20; tick();
      push = 1; raddr = 32'h30; tick();
      push = 1; raddr = 32'h44; pop = 1; tick();
      check("pushpop_pc", curr_pc_o, 32'h30);
      pop = 1; tick();
      check("pushpop_top", curr_pc_o, 32'h44);
      pop = 1; tick();
      check("pushpop_below", curr_pc_o, 32'h20);

      flow = FLOW_STOP; trap = 1; tpc = 32'h400; push = 1; raddr = 32'h9; tick();
      check("trap_no_push", 32'(ras_empty_o), 32'd1);

      redir = 1; rpc = 32'hFFFF_FFFC; tick();
      tick();
      check("wrap", curr_pc_o, 32'h0);

      tick();
      flow = 2'd3; tick();
      check("undef_flow_pc", curr_pc_o, RV);
      check("undef_flow_valid", 32'(pc_valid_o), 32'd0);

`ifdef RVC_EN
      redir = 1; rpc = 32'h2; tick();
      len16 = 1; tick();
      check("rvc_inc", curr_pc_o, 32'h4);
      redir = 1; rpc = 32'h7; tick();
      check("rvc_misalign", 32'(misalign_o), 32'd1);
`else
      redir = 1; rpc = 32'h6; tick();
      check("misalign", 32'(misalign_o), 32'd1);
      len16 = 1; tick();
      check("len16_ignored", curr_pc_o, 32'hA);
`endif
      push = 1; raddr = 32'h123; tick();
      jtag = 1; tick();
      check("jtag_pc", curr_pc_o, RV);
      check("jtag_empty", 32'(ras_empty_o), 32'd1);

      push = 1; raddr = 32'h50; tick();
      push = 1; raddr = 32'h60; tick();
      rst_n = 0; tick();
      rst_n = 1; tick();
      check("post_rst_pc", curr_pc_o, RV + 32'd4);
      check("post_rst_empty", 32'(ras_empty_o), 32'd1);

      for (int n = 0; n < 400; n++) begin
         int f;
         f     = $urandom_range(0, 11);
         flow  = (f < 8) ? FLOW_WORK : (f < 10) ? FLOW_STOP : 2'($urandom_range(2, 3));
         trap  = ($urandom_range(0, 15) == 0);
         tpc   = $urandom;
         redir = ($urandom_range(0, 5) == 0);
         rpc   = $urandom;
         push  = ($urandom_range(0, 2) == 0);
         raddr = $urandom;
         pop   = ($urandom_range(0, 2) == 0);
         len16 = 1'($urandom_range(0, 1));
         jtag  = ($urandom_range(0, 49) == 0);
         rst_n = ($urandom_range(0, 59) != 0);
         tick();
      end
      rst_n = 1;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
